// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave frame engine.
// Used by spi_pin_sync and spi_slave_if.
package spi_slave_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_state_e;

    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-stage synchroniser for sclk/mosi/ss with sclk and ss edge detection.
// Edges compare the synced level against one more registered copy.
module spi_pin_sync
    import spi_slave_pkg::*;
#(
    parameter logic SCLK_IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic mosi,
    input  logic ss,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_sync,
    output logic ss_fall,
    output logic ss_rise
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic [SYNC_STAGES-1:0] ss_ff;
    logic                   sclk_q;
    logic                   ss_q;

    // ss resets low so a master already mid-frame cannot fake a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_ff <= {SYNC_STAGES{SCLK_IDLE}};
            mosi_ff <= '0;
            ss_ff   <= '0;
            sclk_q  <= SCLK_IDLE;
            ss_q    <= 1'b0;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
            ss_ff   <= {ss_ff[SYNC_STAGES-2:0], ss};
            sclk_q  <= sclk_ff[SYNC_STAGES-1];
            ss_q    <= ss_ff[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_q;
    assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] & sclk_q;
    assign mosi_sync = mosi_ff[SYNC_STAGES-1];
    assign ss_fall   = ~ss_ff[SYNC_STAGES-1] & ss_q;
    assign ss_rise   = ss_ff[SYNC_STAGES-1] & ~ss_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave frame engine: oversampled pins, MSB-first rx/tx shift, word handshakes.
// Optional SPI_SLAVE_FRAME_STATUS_EN adds rx_ack and frame_err (short frame / overrun).
module spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter bit                CLK_POLARITY = 1'b0,
    parameter bit                CLK_PHASE    = 1'b0,
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] IDLE_TX_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun
`ifdef SPI_SLAVE_FRAME_STATUS_EN
    ,
    input  logic              rx_ack,
    output logic              frame_err
`endif
);

    localparam int            CW       = cnt_width(DATA_W);
    localparam logic [CW-1:0] FULL     = CW'(DATA_W);
    localparam logic          ON_RISE  = sample_on_rise(CLK_POLARITY, CLK_PHASE);

    logic              sclk_rise;
    logic              sclk_fall;
    logic              mosi_sync;
    logic              ss_fall;
    logic              ss_rise;
    logic              sample_edge;
    logic              change_edge;

    spi_state_e        state_q;
    spi_state_e        state_d;
    logic              frame_start;
    logic              do_sample;
    logic              do_change;
    logic              complete;
    logic              abort;
    logic              leave;

    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic [DATA_W-1:0] load_word;
    logic              accept;

    spi_pin_sync #(
        .SCLK_IDLE (CLK_POLARITY)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss        (ss),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_sync (mosi_sync),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise)
    );

    assign sample_edge = ON_RISE ? sclk_rise : sclk_fall;
    assign change_edge = ON_RISE ? sclk_fall : sclk_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        do_sample   = 1'b0;
        do_change   = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d     = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt == FULL) begin
                    complete = 1'b1;
                    state_d  = ss_rise ? IDLE : DONE;
                end else if (ss_rise) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    do_sample = sample_edge;
                    do_change = change_edge;
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign leave    = (state_q != IDLE) && (state_d == IDLE);
    assign tx_ready = ~hold_full;
    // With the holding register empty a same-cycle push bypasses it
    assign accept   = tx_valid && tx_ready && !frame_start;

    always_comb begin
        load_word = IDLE_TX_WORD;
        if (hold_full) begin
            load_word = hold_data;
        end else if (tx_valid) begin
            load_word = tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (accept) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
            if (frame_start) begin
                bit_cnt     <= '0;
                rx_sr       <= '0;
                tx_sr       <= load_word;
                miso_oe     <= 1'b1;
                miso        <= CLK_PHASE ? 1'b0 : load_word[DATA_W-1];
                hold_full   <= 1'b0;
                tx_underrun <= ~hold_full & ~tx_valid;
            end
            if (do_sample) begin
                rx_sr   <= {rx_sr[DATA_W-2:0], mosi_sync};
                bit_cnt <= bit_cnt + CW'(1);
            end
            // First leading edge in phase 1 only presents the MSB
            if (do_change) begin
                if (CLK_PHASE && bit_cnt == '0) begin
                    miso <= tx_sr[DATA_W-1];
                end else begin
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    miso  <= tx_sr[DATA_W-2];
                end
            end
            if (complete) begin
                rx_data  <= rx_sr;
                rx_valid <= 1'b1;
            end
            if (leave) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_STATUS_EN
    logic rx_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_pend   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= (abort && bit_cnt != '0) ||
                         (complete && rx_pend && !rx_ack);
            if (complete) begin
                rx_pend <= 1'b1;
            end else if (rx_ack) begin
                rx_pend <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench: mode 0 and mode 3 instances driven by a bit-banged SPI master.
// Covers reply/receive, underrun, short frame, mid-frame reset and back-to-back frames.
module tb_spi_slave_if;

    localparam int H = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sclk_p = 2'b10;
    logic [1:0]  ss_p = 2'b11;
    logic [1:0]  mosi_p = 2'b00;
    logic [1:0]  txv = 2'b00;
    logic [15:0] txd [2];
    wire  [1:0]  miso_p;
    wire  [1:0]  oe_p;
    wire  [1:0]  txr_p;
    wire  [1:0]  rxv_p;
    wire  [1:0]  und_p;
    wire  [15:0] rxd0;
    wire  [15:0] rxd1;

    int total = 0;
    int bad = 0;
    int nrx0 = 0;
    int nrx1 = 0;
    int nund0 = 0;
    logic [15:0] log0 [$];

`ifdef SPI_SLAVE_FRAME_STATUS_EN
    wire  [1:0]  ferr;
    int nerr0 = 0;
`endif

    always #5 clk = ~clk;

    spi_slave_if #(
        .CLK_POLARITY (1'b0),
        .CLK_PHASE    (1'b0),
        .DATA_W       (16),
        .IDLE_TX_WORD (16'h0000)
    ) u_m0 (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk_p[0]),
        .mosi        (mosi_p[0]),
        .ss          (ss_p[0]),
        .miso        (miso_p[0]),
        .miso_oe     (oe_p[0]),
        .tx_data     (txd[0]),
        .tx_valid    (txv[0]),
        .tx_ready    (txr_p[0]),
        .rx_data     (rxd0),
        .rx_valid    (rxv_p[0]),
        .tx_underrun (und_p[0])
`ifdef SPI_SLAVE_FRAME_STATUS_EN
        ,
        .rx_ack      (rxv_p[0]),
        .frame_err   (ferr[0])
`endif
    );

    spi_slave_if #(
        .CLK_POLARITY (1'b1),
        .CLK_PHASE    (1'b1),
        .DATA_W       (16),
        .IDLE_TX_WORD (16'h0000)
    ) u_m3 (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk_p[1]),
        .mosi        (mosi_p[1]),
        .ss          (ss_p[1]),
        .miso        (miso_p[1]),
        .miso_oe     (oe_p[1]),
        .tx_data     (txd[1]),
        .tx_valid    (txv[1]),
        .tx_ready    (txr_p[1]),
        .rx_data     (rxd1),
        .rx_valid    (rxv_p[1]),
        .tx_underrun (und_p[1])
`ifdef SPI_SLAVE_FRAME_STATUS_EN
        ,
        .rx_ack      (rxv_p[1]),
        .frame_err   (ferr[1])
`endif
    );

    always @(negedge clk) begin
        if (rxv_p[0]) begin
            nrx0 <= nrx0 + 1;
            log0.push_back(rxd0);
        end
        if (rxv_p[1]) nrx1 <= nrx1 + 1;
        if (und_p[0]) nund0 <= nund0 + 1;
`ifdef SPI_SLAVE_FRAME_STATUS_EN
        if (ferr[0]) nerr0 <= nerr0 + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int m, input logic [15:0] d);
        @(negedge clk);
        txd[m] = d;
        txv[m] = 1'b1;
        @(negedge clk);
        txv[m] = 1'b0;
    endtask

    // Bit-banged master: m=0 is mode 0, m=1 is mode 3
    task automatic xfer(input int m, input logic [15:0] mo, input int nbits,
                        input bit raise, output logic [15:0] mi);
        mi = '0;
        ss_p[m] = 1'b0;
        #(100);
        for (int i = 0; i < nbits; i++) begin
            if (m == 0) begin
                mosi_p[m] = mo[15-i];
                #(H);
                mi = {mi[14:0], miso_p[m]};
                sclk_p[m] = 1'b1;
                #(H);
                sclk_p[m] = 1'b0;
            end else begin
                sclk_p[m] = 1'b0;
                mosi_p[m] = mo[15-i];
                #(H);
                mi = {mi[14:0], miso_p[m]};
                sclk_p[m] = 1'b1;
                #(H);
            end
        end
        if (raise) begin
            ss_p[m] = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] mi;
        int b0;
        int b1;
        int u0;
        txd[0] = '0;
        txd[1] = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_ready", {30'd0, txr_p}, 32'h3);
        check("rst_oe", {30'd0, oe_p}, 32'h0);
        check("rst_miso", {30'd0, miso_p}, 32'h0);
        check("rst_rx_data", {16'd0, rxd0}, 32'h0);
        check("rst_pulses", {28'd0, rxv_p, und_p}, 32'h0);

        // Mode 0 with reply loaded ahead of the frame
        push(0, 16'h3C5A);
        check("m0_ready_low", {31'd0, txr_p[0]}, 32'h0);
        b0 = nrx0;
        u0 = nund0;
        xfer(0, 16'hA5C3, 16, 1'b1, mi);
        check("m0_miso_word", {16'd0, mi}, 32'h3C5A);
        check("m0_rx_data", {16'd0, rxd0}, 32'hA5C3);
        check("m0_rx_pulses", b0 - nrx0 + 2 * (nrx0 - b0), 1);
        check("m0_no_underrun", nund0 - u0, 0);
        check("m0_ready_high", {31'd0, txr_p[0]}, 32'h1);
        check("m0_oe_off", {31'd0, oe_p[0]}, 32'h0);

        // Mode 3
        push(1, 16'hFFFF);
        b1 = nrx1;
        xfer(1, 16'h0001, 16, 1'b1, mi);
        check("m3_miso_word", {16'd0, mi}, 32'hFFFF);
        check("m3_rx_data", {16'd0, rxd1}, 32'h0001);
        check("m3_rx_pulses", nrx1 - b1, 1);
        check("m3_oe_off", {31'd0, oe_p[1]}, 32'h0);

        // Underrun: nothing pending
        u0 = nund0;
        xfer(0, 16'h1234, 16, 1'b1, mi);
        check("ur_pulse", nund0 - u0, 1);
        check("ur_miso_word", {16'd0, mi}, 32'h0000);
        check("ur_rx_data", {16'd0, rxd0}, 32'h1234);

        // Short frame of 9 bits
        b0 = nrx0;
`ifdef SPI_SLAVE_FRAME_STATUS_EN
        b1 = nerr0;
`endif
        xfer(0, 16'hBEEF, 9, 1'b1, mi);
        check("short_no_valid", nrx0 - b0, 0);
        check("short_rx_kept", {16'd0, rxd0}, 32'h1234);
        check("short_oe_off", {31'd0, oe_p[0]}, 32'h0);
`ifdef SPI_SLAVE_FRAME_STATUS_EN
        check("short_frame_err", nerr0 - b1, 1);
`endif

        // Reset in the middle of a frame with a word pending
        xfer(0, 16'hCAFE, 8, 1'b0, mi);
        push(0, 16'h7777);
        check("mid_ready_low", {31'd0, txr_p[0]}, 32'h0);
        b0 = nrx0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_ready_high", {31'd0, txr_p[0]}, 32'h1);
        check("mid_oe_off", {31'd0, oe_p[0]}, 32'h0);
        ss_p[0] = 1'b1;
        repeat (6) @(negedge clk);
        u0 = nund0;
        xfer(0, 16'h5555, 16, 1'b1, mi);
        check("mid_rx_data", {16'd0, rxd0}, 32'h5555);
        check("mid_rx_pulses", nrx0 - b0, 1);
        check("mid_hold_dropped", {16'd0, mi}, 32'h0000);
        check("mid_underrun", nund0 - u0, 1);

        // Back-to-back frames, reply for frame 2 pushed during frame 1
        push(0, 16'h6B6B);
        log0.delete();
        b0 = nrx0;
        fork
            xfer(0, 16'h0F0F, 16, 1'b1, mi);
            begin
                #(1200);
                push(0, 16'h9D9D);
            end
        join
        check("b2b_f1_miso", {16'd0, mi}, 32'h6B6B);
        xfer(0, 16'hF0F0, 16, 1'b1, mi);
        check("b2b_f2_miso", {16'd0, mi}, 32'h9D9D);
        check("b2b_pulses", nrx0 - b0, 2);
        if (log0.size() == 2) begin
            check("b2b_rx1", {16'd0, log0[0]}, 32'h0F0F);
            check("b2b_rx2", {16'd0, log0[1]}, 32'hF0F0);
        end else begin
            check("b2b_log_size", log0.size(), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Synthesisable SPI slave frame engine.
- Sits directly downstream of the SPI master bus model. It consumes sclk/mosi/ss and drives miso back.
- Oversamples the SPI pins in the system clock domain, deserialises 16-bit frames MSB-first and serialises a 16-bit reply word.
- Presents valid/ready word interfaces to the uDMA-side logic.

Parameters:
- CLK_POLARITY, 0, idle level of sclk (0 = low, 1 = high).
- CLK_PHASE, 0, 0 = sample on leading edge / change on trailing edge; 1 = change on leading edge / sample on trailing edge.
- DATA_W, 16, frame width in bits (legal 8..32).
- IDLE_TX_WORD, 16'h0000, word shifted out when no tx word is pending at frame start.

Ports:
- clk  in  1  system clock; must be >= 8x sclk frequency.
- rst  in  1  synchronous active-high reset.
- sclk  in  1  SPI clock from master (asynchronous to clk).
- mosi  in  1  SPI data from master.
- ss  in  1  active-low slave select.
- miso  out  1  SPI data to master.
- miso_oe  out  1  miso output enable, high while selected.
- tx_data  in  DATA_W  reply word.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse: frame started with no tx word pending.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, state=IDLE, bit count=0, holding register empty.
- Input sync: sclk, mosi and ss each pass through a 2-FF synchroniser. Edges are detected on the synced sclk by comparing against a third registered copy.
- Edge mapping: sample edge = rising when CLK_POLARITY==CLK_PHASE, else falling. Change edge is the opposite edge.
- TX holding register:
  - Accepts a word when tx_valid && tx_ready; tx_ready drops the next cycle.
  - Moved into the shift register at frame start, after which tx_ready rises the next cycle.
  - A transfer on the same cycle as frame start is loaded directly into the shift register, with no underrun.
- State IDLE → SHIFT on synced ss falling:
  - Load the shift register from holding, or from IDLE_TX_WORD and pulse tx_underrun.
  - Clear the bit count; miso_oe=1.
  - CLK_PHASE=0: miso = MSB from the same cycle.
  - CLK_PHASE=1: MSB is driven on the first change edge.
- State SHIFT:
  - Each sample edge: rx shift {rx_sr, mosi_sync}, bit count +1.
  - Each change edge: tx shift left, miso = new MSB. CLK_PHASE=0 ignores the final trailing edge after bit DATA_W.
  - When the bit count reaches DATA_W, go to DONE. rx_data is loaded and rx_valid pulses on the cycle after the DATA_W-th synced sample edge.
- State DONE: extra sclk edges are ignored, miso holds its last value, and no second rx_valid is produced. On synced ss rising, go to IDLE.
- ss rising in SHIFT (short frame): abort to IDLE, no rx_valid, rx_data unchanged, partial data discarded.
- IDLE: miso=0, miso_oe=0. Any sclk edges are ignored.
- Simultaneous ss fall and sclk edge in the same synced cycle: frame start takes priority and that edge is ignored. Masters must leave >= 2 clk between ss fall and the first sclk edge.
- Reset mid-frame: immediate return to IDLE; the current frame and any pending holding word are dropped.
- End-to-end latency: pad sample edge to rx_valid = 4 clk (2 sync + 1 edge detect + 1 register).

Optional Feature:
- Macro: SPI_SLAVE_FRAME_STATUS_EN.
- Defined: adds output port frame_err (1 bit), pulsed for one cycle when ss rises while in SHIFT with 0 < bit count < DATA_W. Also adds an overrun check: frame_err pulses if a new frame completes while the previous rx_valid has not been followed by an rx_ack input pulse (rx_ack is also added).
- Undefined: neither port exists, and short frames and overruns are silent.

Decomposition:
- Package spi_slave_pkg:
  - typedef spi_state_e {IDLE, SHIFT, DONE}
  - function sample_on_rise(cpol, cpha)
  - localparam SYNC_STAGES=2
  - bit-count width function $clog2(DATA_W+1)
- Sub-module spi_pin_sync: 3-input 2-FF synchroniser plus sclk rise/fall detector.

Test Plan:
- Mode 0 (CPOL=0,CPHA=0), tx 16'h3C5A loaded before ss falls, master sends 16'hA5C3 → rx_data=16'hA5C3, single rx_valid pulse, master reads 16'h3C5A.
- Mode 3 (CPOL=1,CPHA=1), tx 16'hFFFF, master sends 16'h0001 → rx_data=16'h0001, master reads 16'hFFFF, miso_oe low after ss high.
- No tx word pending, master sends 16'h1234 → tx_underrun pulse at frame start, master reads 16'h0000, rx_data=16'h1234.
- ss raised after 9 bits of 16'hBEEF → no rx_valid, rx_data keeps its previous value; with SPI_SLAVE_FRAME_STATUS_EN defined, frame_err pulses once.
- rst asserted after 8 bits of 16'hCAFE, then a clean frame 16'h5555 → first frame lost, rx_data=16'h5555, tx_ready=1 after reset.
- Back-to-back frames 16'h0F0F, 16'hF0F0 with tx pushed during frame 1 → two rx_valid pulses carrying the correct data; frame 2 replies with the pushed word.
